// File: rtl/ksa_param_if.sv
// ARC4 key-schedule bus: start/ready handshake, key and the single-port S-box RAM port.
// Latency: none; this bundles signals only.
// Backpressure: en is honoured only while rdy=1; the RAM side has no stall.
interface ksa_param_if #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
);
  logic                   en;
  logic                   rdy;
  logic                   done;
  logic [KEY_BYTES*8-1:0] key;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W-1:0]      rddata;
  logic [ADDR_W-1:0]      wrdata;
  logic                   wren;

  // Control FSM / RAM side: requests runs and returns RAM read data.
  modport master (
    output en, key, rddata,
    input  rdy, done, addr, wrdata, wren
  );

  // Key-scheduling engine side.
  modport slave (
    input  en, key, rddata,
    output rdy, done, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa_param.sv
// Parametrised ARC4 key scheduler permuting an external S-box RAM in place (optional INIT phase: KSA_PARAM_INIT_PHASE_EN).
// Latency: 4 cycles per entry, done 4N cycles after accept (5N with the INIT phase).
// Backpressure: en ignored while busy (rdy=0); key is latched on accept, so later key changes are ignored.
module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input logic        clk,
  input logic        rst,
  ksa_param_if.slave bus
);

  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST    = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RD_I = 3'd2,
    ST_RD_J = 3'd3,
    ST_WR_I = 3'd4,
    ST_WR_J = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [ADDR_W-1:0]      si_q, si_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;

  // Low ADDR_W bits of the current key byte (byte 0 is the MSB byte); this is the byte mod N.
  logic [ADDR_W-1:0] key_byte;
  logic [ADDR_W-1:0] jn;

  assign key_byte = key_q[(KEY_BYTES - 1 - int'(kidx_q)) * 8 +: ADDR_W];
  // rddata holds S[i] during RD_J; the ADDR_W-bit sum wraps mod N for free.
  assign jn = j_q + bus.rddata + key_byte;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          key_d  = bus.key;
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
`ifdef KSA_PARAM_INIT_PHASE_EN
          state_d = ST_INIT;
`else
          state_d = ST_RD_I;
`endif
        end
      end
`ifdef KSA_PARAM_INIT_PHASE_EN
      ST_INIT: begin
        // i wraps back to 0 on the last fill write, ready for the swap loop.
        i_d = i_q + ADDR_W'(1);
        if (i_q == I_LAST) state_d = ST_RD_I;
      end
`endif
      ST_RD_I: state_d = ST_RD_J;
      ST_RD_J: begin
        si_d    = bus.rddata;
        j_d     = jn;
        state_d = ST_WR_I;
      end
      ST_WR_I: state_d = ST_WR_J;
      ST_WR_J: begin
        i_d     = i_q + ADDR_W'(1);
        kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
        state_d = (i_q == I_LAST) ? ST_DONE : ST_RD_I;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; S[i] is written before S[j] so i==j rewrites the same value twice.
  always_comb begin
    bus.rdy    = 1'b0;
    bus.done   = 1'b0;
    bus.addr   = '0;
    bus.wrdata = '0;
    bus.wren   = 1'b0;
    case (state_q)
      ST_IDLE: bus.rdy = 1'b1;
`ifdef KSA_PARAM_INIT_PHASE_EN
      ST_INIT: begin
        bus.addr   = i_q;
        bus.wrdata = i_q;
        bus.wren   = 1'b1;
      end
`endif
      ST_RD_I: bus.addr = i_q;
      ST_RD_J: bus.addr = jn;
      ST_WR_I: begin
        bus.addr   = i_q;
        bus.wrdata = bus.rddata;
        bus.wren   = 1'b1;
      end
      ST_WR_J: begin
        bus.addr   = j_q;
        bus.wrdata = si_q;
        bus.wren   = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_param.sv
// Bench for ksa_param: default 3-byte/256-entry engine plus a 5-byte/16-entry instance.
// Latency: expected done cycles are queued at stimulus time and popped on the done pulse.
// Backpressure: exercises en while busy, reset mid-run and en held high for back-to-back runs.
module tb_ksa_param;
  typedef logic [255:0][7:0] sbox_t;

`ifdef KSA_PARAM_INIT_PHASE_EN
  localparam int INIT0 = 256;
  localparam int INIT1 = 16;
`else
  localparam int INIT0 = 0;
  localparam int INIT1 = 0;
`endif
  localparam int LAT0 = INIT0 + 1024;
  localparam int LAT1 = INIT1 + 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt0 = 0;
  int   fill0 = 0;  // 0: normal, 1: identity, 2: 0xAA everywhere
  int   fill1 = 0;

  sbox_t exp_s_q[$];
  int    exp_t_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ksa_param_if #(.KEY_BYTES(3), .ADDR_W(8)) bus0();
  ksa_param_if #(.KEY_BYTES(5), .ADDR_W(4)) bus1();

  ksa_param #(.KEY_BYTES(3), .ADDR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ksa_param #(.KEY_BYTES(5), .ADDR_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Single-port synchronous-read RAMs with a bench-side bulk fill.
  logic [7:0] mem0 [256];
  logic [3:0] mem1 [16];
  logic [7:0] rd0;
  logic [3:0] rd1;

  always @(posedge clk) begin
    if (fill0 == 1)      for (int k = 0; k < 256; k++) mem0[k] <= 8'(k);
    else if (fill0 == 2) for (int k = 0; k < 256; k++) mem0[k] <= 8'hAA;
    else if (bus0.wren)  mem0[bus0.addr] <= bus0.wrdata;
    rd0 <= mem0[bus0.addr];
    if (fill1 == 1)      for (int k = 0; k < 16; k++) mem1[k] <= 4'(k);
    else if (fill1 == 2) for (int k = 0; k < 16; k++) mem1[k] <= 4'hA;
    else if (bus1.wren)  mem1[bus1.addr] <= bus1.wrdata;
    rd1 <= mem1[bus1.addr];
    if (bus0.done) done_cnt0 <= done_cnt0 + 1;
  end

  assign bus0.rddata = rd0;
  assign bus1.rddata = rd1;

  // Reference ARC4 key schedule over n entries with a kb-byte key (byte 0 = MSB byte).
  function automatic sbox_t ksa_model(input sbox_t s_in, input logic [255:0] key, input int kb, input int n);
    sbox_t s = s_in;
    int j = 0;
    int kbyte;
    logic [7:0] t;
    for (int i = 0; i < n; i++) begin
      kbyte = int'((key >> (8 * (kb - 1 - (i % kb)))) & 256'hFF);
      j = (j + int'(s[i]) + kbyte) % n;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    return s;
  endfunction

  function automatic sbox_t ident(input int n);
    sbox_t s = '0;
    for (int k = 0; k < n; k++) s[k] = 8'(k);
    return s;
  endfunction

  function automatic sbox_t snap(input int sel);
    sbox_t s = '0;
    if (sel == 0) for (int k = 0; k < 256; k++) s[k] = mem0[k];
    else          for (int k = 0; k < 16; k++)  s[k] = {4'h0, mem1[k]};
    return s;
  endfunction

  function automatic int first_diff(input sbox_t a, input sbox_t b);
    for (int k = 0; k < 256; k++) if (a[k] !== b[k]) return k;
    return -1;
  endfunction

  task automatic do_fill(input int sel, input int mode);
    if (sel == 0) fill0 = mode; else fill1 = mode;
    @(negedge clk);
    fill0 = 0;
    fill1 = 0;
  endtask

  // Pulses en for one cycle; optionally queues the expected done cycle and final S-box.
  task automatic start_run(input int sel, input logic [255:0] k, input int lat, input bit push, input sbox_t e);
    if (push) begin
      exp_t_q.push_back(cyc + 1 + lat);
      exp_s_q.push_back(e);
    end
    if (sel == 0) begin bus0.key = k[23:0]; bus0.en = 1'b1; end
    else          begin bus1.key = k[39:0]; bus1.en = 1'b1; end
    @(negedge clk);
    bus0.en = 1'b0;
    bus1.en = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int bound, output int t, output bit seen);
    seen = 1'b0;
    t = -1;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if ((sel == 0 && bus0.done === 1'b1) || (sel == 1 && bus1.done === 1'b1)) begin
        seen = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus0.en = 1'b0; bus1.en = 1'b0;
    bus0.key = '0;  bus1.key = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus0.rdy !== 1'b1)    begin n_bad++; $display("FAIL reset_rdy: got %b want 1", bus0.rdy); end
    n_cmp++; if (bus0.done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", bus0.done); end
    n_cmp++; if (bus0.wren !== 1'b0)   begin n_bad++; $display("FAIL reset_wren: got %b want 0", bus0.wren); end
    n_cmp++; if (bus0.addr !== 8'h00)  begin n_bad++; $display("FAIL reset_addr: got %h want 00", bus0.addr); end
    n_cmp++; if (bus0.wrdata !== 8'h00) begin n_bad++; $display("FAIL reset_wrdata: got %h want 00", bus0.wrdata); end
    n_cmp++; if (bus1.rdy !== 1'b1)    begin n_bad++; $display("FAIL reset_rdy1: got %b want 1", bus1.rdy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    sbox_t e, got;
    int a, t, et, d;
    bit seen;
    do_fill(0, (INIT0 > 0) ? 2 : 1);
    e = ksa_model(ident(256), 256'h00033C, 3, 256);
    a = cyc + 1;
    start_run(0, 256'h00033C, LAT0, 1'b1, e);
`ifdef KSA_PARAM_INIT_PHASE_EN
    while (cyc < a + INIT0) @(negedge clk);
    got = snap(0);
    d = first_diff(got, ident(256));
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL init_fill: S[%0d]=%h want %h", d, got[d], 8'(d)); end
`endif
    while (cyc < a + INIT0 + 8) @(negedge clk);
    n_cmp++; if (mem0[0] !== 8'h00) begin n_bad++; $display("FAIL basic_s0: got %h want 00", mem0[0]); end
    n_cmp++; if (mem0[1] !== 8'h04 || mem0[4] !== 8'h01)
      begin n_bad++; $display("FAIL basic_swap1: S[1]=%h S[4]=%h want 04 01", mem0[1], mem0[4]); end
    n_cmp++; if (bus0.rdy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_rdy: got %b want 0", bus0.rdy); end
    wait_done(0, LAT0 + 50, t, seen);
    et = exp_t_q.pop_front();
    e = exp_s_q.pop_front();
    n_cmp++; if (!seen || t != et) begin n_bad++; $display("FAIL basic_done_time: got %0d want %0d", t, et); end
    got = snap(0);
    d = first_diff(got, e);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL basic_sbox: S[%0d]=%h want %h", d, got[d], e[d]); end
    @(negedge clk);
    n_cmp++; if (bus0.done !== 1'b0 || bus0.rdy !== 1'b1)
      begin n_bad++; $display("FAIL basic_after_done: done=%b rdy=%b want 0 1", bus0.done, bus0.rdy); end
  endtask

  task automatic test_param;
    sbox_t e, got;
    int a, t, et, d;
    bit seen;
    do_fill(1, (INIT1 > 0) ? 2 : 1);
    e = ksa_model(ident(16), 256'h0102030405, 5, 16);
    a = cyc + 1;
    start_run(1, 256'h0102030405, LAT1, 1'b1, e);
    while (cyc < a + INIT1 + 4) @(negedge clk);
    n_cmp++; if (mem1[0] !== 4'h1 || mem1[1] !== 4'h0)
      begin n_bad++; $display("FAIL param_swap0: S[0]=%h S[1]=%h want 1 0", mem1[0], mem1[1]); end
    wait_done(1, LAT1 + 50, t, seen);
    et = exp_t_q.pop_front();
    e = exp_s_q.pop_front();
    n_cmp++; if (!seen || t != et) begin n_bad++; $display("FAIL param_done_time: got %0d want %0d", t, et); end
    got = snap(1);
    d = first_diff(got, e);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL param_sbox: S[%0d]=%h want %h", d, got[d], e[d]); end
  endtask

  task automatic test_ignore_en;
    sbox_t e, got;
    int t, et, d, c0;
    bit seen;
    do_fill(0, 1);
    e = ksa_model(ident(256), 256'h00033C, 3, 256);
    c0 = done_cnt0;
    start_run(0, 256'h00033C, LAT0, 1'b1, e);
    repeat (100) @(negedge clk);
    bus0.key = 24'hFFFFFF;
    bus0.en = 1'b1;
    repeat (50) @(negedge clk);
    bus0.en = 1'b0;
    wait_done(0, LAT0 + 50, t, seen);
    et = exp_t_q.pop_front();
    e = exp_s_q.pop_front();
    n_cmp++; if (!seen || t != et) begin n_bad++; $display("FAIL ignore_done_time: got %0d want %0d", t, et); end
    got = snap(0);
    d = first_diff(got, e);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL ignore_sbox: S[%0d]=%h want %h", d, got[d], e[d]); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt0 - c0 != 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt0 - c0); end
  endtask

  task automatic test_rst_mid;
    sbox_t e, got, base;
    int a, t, et, d, c0;
    bit seen;
    do_fill(0, 1);
    c0 = done_cnt0;
    a = cyc + 1;
    start_run(0, 256'h00033C, LAT0, 1'b0, '0);
    while (cyc < a + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.rdy !== 1'b1 || bus0.wren !== 1'b0 || bus0.addr !== 8'h00)
      begin n_bad++; $display("FAIL rst_mid_outputs: rdy=%b wren=%b addr=%h want 1 0 00", bus0.rdy, bus0.wren, bus0.addr); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (done_cnt0 != c0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt0 - c0); end
    base = (INIT0 > 0) ? ident(256) : snap(0);
    e = ksa_model(base, 256'h00033C, 3, 256);
    start_run(0, 256'h00033C, LAT0, 1'b1, e);
    wait_done(0, LAT0 + 50, t, seen);
    et = exp_t_q.pop_front();
    e = exp_s_q.pop_front();
    n_cmp++; if (!seen || t != et) begin n_bad++; $display("FAIL rst_rerun_time: got %0d want %0d", t, et); end
    got = snap(0);
    d = first_diff(got, e);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL rst_rerun_sbox: S[%0d]=%h want %h", d, got[d], e[d]); end
  endtask

  task automatic test_back_to_back;
    sbox_t e1, e2, got;
    int t1, t2, et, d;
    bit seen;
    do_fill(0, 1);
    e1 = ksa_model(ident(256), 256'h00033C, 3, 256);
    e2 = ksa_model((INIT0 > 0) ? ident(256) : e1, 256'h00033C, 3, 256);
    exp_t_q.push_back(cyc + 1 + LAT0);
    exp_s_q.push_back(e1);
    exp_t_q.push_back(cyc + 1 + 2 * LAT0 + 2);
    exp_s_q.push_back(e2);
    bus0.key = 24'h00033C;
    bus0.en = 1'b1;
    wait_done(0, LAT0 + 50, t1, seen);
    got = snap(0);
    et = exp_t_q.pop_front();
    e1 = exp_s_q.pop_front();
    n_cmp++; if (!seen || t1 != et) begin n_bad++; $display("FAIL b2b_done1_time: got %0d want %0d", t1, et); end
    d = first_diff(got, e1);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL b2b_sbox1: S[%0d]=%h want %h", d, got[d], e1[d]); end
    @(negedge clk);
    n_cmp++; if (bus0.rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_rdy: got %b want 1", bus0.rdy); end
    @(negedge clk);
    n_cmp++; if (bus0.rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_restart_rdy: got %b want 0", bus0.rdy); end
    wait_done(0, LAT0 + 50, t2, seen);
    bus0.en = 1'b0;
    et = exp_t_q.pop_front();
    e2 = exp_s_q.pop_front();
    n_cmp++; if (!seen || t2 != et) begin n_bad++; $display("FAIL b2b_done2_time: got %0d want %0d", t2, et); end
    got = snap(0);
    d = first_diff(got, e2);
    n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL b2b_sbox2: S[%0d]=%h want %h", d, got[d], e2[d]); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus0.rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_final_idle: got %b want 1", bus0.rdy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_param();
    test_ignore_en();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
